// File: rtl/interrupt_push_sequencer.sv
// Interrupt entry sequencer: pushes PCH/PCL/P, fetches the
// NMI or IRQ/BRK vector, pulses set_i and hands back PC and SP.
//
// Ports:
//   clk, nrst        clock, async active-low reset
//   instr_boundary   only cycle a sequence may start
//   nmi_n            NMI line, falling-edge sensitive
//   irq_n            IRQ line, level sensitive, active low
//   brk_req          BRK decoded (with instr_boundary)
//   psr_in           status register, pushed as P
//   pc_in            PC to push (PC+2 for BRK)
//   sp_in            stack pointer at start
//   data_in          read data, valid the cycle after read_en
//   addr             bus address
//   data_out         bus write data
//   write_en         memory write strobe
//   read_en          memory read strobe
//   sp_out           updated SP, valid with done
//   set_i            one-cycle manual-I set pulse
//   pc_new           vector target, valid with done
//   done             one-cycle load pulse
//   busy             high from PUSH_PCH through LOAD
module interrupt_push_sequencer #(
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_boundary,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic [7:0]  psr_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        write_en,
  output logic        read_en,
  output logic [7:0]  sp_out,
  output logic        set_i,
  output logic [15:0] pc_new,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PCH  = 3'd1;
  localparam logic [2:0] S_PCL  = 3'd2;
  localparam logic [2:0] S_P    = 3'd3;
  localparam logic [2:0] S_VLO  = 3'd4;
  localparam logic [2:0] S_VHI  = 3'd5;
  localparam logic [2:0] S_LOAD = 3'd6;

  logic [2:0]  state;
  logic [7:0]  sp;
  logic [7:0]  vec_lo;
  logic        nmi_q;
  logic        nmi_pending;
  logic        src_brk;
  logic        vec_nmi;

  logic        nmi_edge;
  logic        irq_ok;
  logic        start;
  logic        use_nmi;
  logic [15:0] vec;
  logic [15:0] stack_addr;
  logic [7:0]  p_push;

  assign nmi_edge   = nmi_q & ~nmi_n;
  assign irq_ok     = ~irq_n & ~psr_in[2];
  assign start      = (state == S_IDLE) & instr_boundary &
                      (nmi_pending | irq_ok | brk_req);
  // The vector is decided in VEC_LO; a late NMI hijacks it.
  assign use_nmi    = (state == S_VLO) ? nmi_pending : vec_nmi;
  assign vec        = use_nmi ? NMI_VECTOR : IRQ_VECTOR;
  assign stack_addr = {STACK_PAGE, sp};
  assign p_push     = {psr_in[7:6], 1'b1, src_brk, psr_in[3:0]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      sp          <= 8'h00;
      vec_lo      <= 8'h00;
      nmi_q       <= 1'b1;
      nmi_pending <= 1'b0;
      src_brk     <= 1'b0;
      vec_nmi     <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      // A fresh edge wins over consumption in the same cycle.
      nmi_pending <= nmi_edge |
                     (nmi_pending & (state != S_VLO));
      case (state)
        S_IDLE: begin
          if (start) begin
            src_brk <= ~nmi_pending & ~irq_ok;
            sp      <= sp_in;
            state   <= S_PCH;
          end
        end
        S_PCH: begin
          sp    <= sp - 8'd1;
          state <= S_PCL;
        end
        S_PCL: begin
          sp    <= sp - 8'd1;
          state <= S_P;
        end
        S_P: begin
          sp    <= sp - 8'd1;
          state <= S_VLO;
        end
        S_VLO: begin
          vec_nmi <= nmi_pending;
          state   <= S_VHI;
        end
        S_VHI: begin
          vec_lo <= data_in;
          state  <= S_LOAD;
        end
        S_LOAD: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr     = 16'h0000;
    data_out = 8'h00;
    write_en = 1'b0;
    read_en  = 1'b0;
    set_i    = 1'b0;
    sp_out   = 8'h00;
    pc_new   = 16'h0000;
    done     = 1'b0;
    busy     = 1'b0;
    unique case (1'b1)
      (state == S_PCH): begin
        addr     = stack_addr;
        data_out = pc_in[15:8];
        write_en = 1'b1;
        busy     = 1'b1;
      end
      (state == S_PCL): begin
        addr     = stack_addr;
        data_out = pc_in[7:0];
        write_en = 1'b1;
        busy     = 1'b1;
      end
      (state == S_P): begin
        addr     = stack_addr;
        data_out = p_push;
        write_en = 1'b1;
        busy     = 1'b1;
      end
      (state == S_VLO): begin
        addr    = vec;
        read_en = 1'b1;
        set_i   = 1'b1;
        busy    = 1'b1;
      end
      (state == S_VHI): begin
        addr    = vec + 16'd1;
        read_en = 1'b1;
        busy    = 1'b1;
      end
      (state == S_LOAD): begin
        pc_new = {data_in, vec_lo};
        sp_out = sp;
        done   = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_push_sequencer.sv
// Randomized bench for interrupt_push_sequencer against a
// cycle-indexed transaction model of the entry sequence.
module tb_interrupt_push_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        instr_boundary;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic [7:0]  psr_in;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        write_en;
  logic        read_en;
  logic [7:0]  sp_out;
  logic        set_i;
  logic [15:0] pc_new;
  logic        done;
  logic        busy;

  interrupt_push_sequencer dut (
    .clk(clk),
    .nrst(nrst),
    .instr_boundary(instr_boundary),
    .nmi_n(nmi_n),
    .irq_n(irq_n),
    .brk_req(brk_req),
    .psr_in(psr_in),
    .pc_in(pc_in),
    .sp_in(sp_in),
    .data_in(data_in),
    .addr(addr),
    .data_out(data_out),
    .write_en(write_en),
    .read_en(read_en),
    .sp_out(sp_out),
    .set_i(set_i),
    .pc_new(pc_new),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // model: ph = cycles since start (0 = idle)
  int         ph;
  logic [7:0] m_sp0;
  bit         m_brk;
  bit         m_vnmi;
  bit         m_pend;
  bit         m_nprev;
  logic [7:0] nmi_lo;
  logic [7:0] nmi_hi;

  function automatic logic [7:0] mem(logic [15:0] a);
    case (a)
      16'hFFFA: return nmi_lo;
      16'hFFFB: return nmi_hi;
      16'hFFFE: return 8'h34;
      16'hFFFF: return 8'h12;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] dut_vec();
    return {11'b0, busy, done, set_i, write_en, read_en,
            addr, data_out, pc_new, sp_out};
  endfunction

  function automatic logic [63:0] expected();
    logic [15:0] a = 16'h0;
    logic [7:0]  d = 8'h0;
    logic [15:0] pn = 16'h0;
    logic [7:0]  so = 8'h0;
    logic [7:0]  s;
    logic [15:0] v;
    bit we = 0, re = 0, si = 0, dn = 0;
    v = m_vnmi ? 16'hFFFA : 16'hFFFE;
    case (ph)
      1: begin
        a = {8'h01, m_sp0}; d = pc_in[15:8]; we = 1;
      end
      2: begin
        s = m_sp0 - 8'd1;
        a = {8'h01, s}; d = pc_in[7:0]; we = 1;
      end
      3: begin
        s = m_sp0 - 8'd2;
        a = {8'h01, s}; we = 1;
        d = (psr_in & 8'hEF) | 8'h20 | (m_brk ? 8'h10 : 8'h00);
      end
      4: begin
        a = m_pend ? 16'hFFFA : 16'hFFFE; re = 1; si = 1;
      end
      5: begin
        a = v + 16'd1; re = 1;
      end
      6: begin
        pn = {mem(v + 16'd1), mem(v)};
        so = m_sp0 - 8'd3; dn = 1;
      end
      default: ;
    endcase
    return {11'b0, ph != 0, dn, si, we, re, a, d, pn, so};
  endfunction

  task automatic model_reset();
    ph = 0; m_pend = 0; m_nprev = 1;
    m_brk = 0; m_vnmi = 0; m_sp0 = 8'h00;
  endtask

  task automatic model_update();
    bit e, irq_ok;
    if (!nrst) begin
      model_reset();
      return;
    end
    e = m_nprev & ~nmi_n;
    m_nprev = nmi_n;
    irq_ok = !irq_n && !psr_in[2];
    if (ph == 0) begin
      if (instr_boundary && (m_pend || irq_ok || brk_req)) begin
        m_brk = !m_pend && !irq_ok;
        m_sp0 = sp_in;
        ph = 1;
      end
    end else if (ph == 4) begin
      m_vnmi = m_pend;
      m_pend = 0;
      ph = 5;
    end else if (ph == 6) begin
      ph = 0;
    end else begin
      ph = ph + 1;
    end
    if (e) m_pend = 1;
  endtask

  // one cycle: drive read data, compare at negedge, advance
  task automatic step(string tag);
    logic [15:0] v;
    v = m_vnmi ? 16'hFFFA : 16'hFFFE;
    if (ph == 5) data_in = mem(v);
    else if (ph == 6) data_in = mem(v + 16'd1);
    else data_in = 8'($urandom);
    @(negedge clk);
    check(tag, dut_vec(), expected());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    instr_boundary = 0; irq_n = 1; brk_req = 0;
  endtask

  task automatic run_seq(string tag, logic [7:0] p,
                         logic [15:0] pc, logic [7:0] sp,
                         logic irq, logic brk);
    psr_in = p; pc_in = pc; sp_in = sp;
    irq_n = irq; brk_req = brk; instr_boundary = 1;
    step(tag);
    quiet();
    for (int i = 0; i < 7; i++) step(tag);
  endtask

  initial begin
    nmi_lo = 8'($urandom);
    nmi_hi = 8'($urandom);
    nrst = 0; nmi_n = 1; psr_in = 0; pc_in = 0; sp_in = 0;
    data_in = 0;
    quiet();
    model_reset();
    #1;
    check("reset_out", dut_vec(), 64'h0);
    repeat (2) step("reset");
    nrst = 1;

    run_seq("irq", 8'h20, 16'h1234, 8'hFD, 1'b0, 1'b0);

    psr_in = 8'h04; irq_n = 0; instr_boundary = 1;
    for (int i = 0; i < 10; i++) step("irq_masked");
    quiet();

    run_seq("brk", 8'hC1, 16'h8002, 8'hFF, 1'b1, 1'b1);

    nmi_n = 0; step("nmi_fall");
    run_seq("nmi_prio", 8'h20, 16'h4000, 8'hF0, 1'b0, 1'b0);
    nmi_n = 1; step("nmi_rise");

    psr_in = 8'h20; pc_in = 16'h5678; sp_in = 8'hE0;
    irq_n = 0; instr_boundary = 1;
    step("hijack");
    quiet();
    step("hijack");
    nmi_n = 0;
    for (int i = 0; i < 6; i++) step("hijack");
    nmi_n = 1;
    instr_boundary = 1;
    step("hijack_clear");
    check("pend_clear_busy", 64'(busy), 64'h0);
    quiet();

    run_seq("sp_wrap", 8'h20, 16'hABCD, 8'h01, 1'b0, 1'b0);

    psr_in = 8'h20; pc_in = 16'h1111; sp_in = 8'h80;
    irq_n = 0; instr_boundary = 1;
    step("rst_mid");
    quiet();
    step("rst_mid");
    step("rst_mid");
    nrst = 0;
    #1;
    check("rst_async", dut_vec(), 64'h0);
    model_reset();
    step("rst_hold");
    step("rst_hold");
    nrst = 1;
    for (int i = 0; i < 4; i++) step("rst_idle");

    for (int i = 0; i < 3000; i++) begin
      if (ph == 0) begin
        psr_in = 8'($urandom);
        pc_in = 16'($urandom);
        sp_in = 8'($urandom);
      end
      instr_boundary = 1'($urandom_range(0, 1));
      irq_n = ($urandom_range(0, 3) != 0);
      brk_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
